// File: rtl/cache_fill_ctrl_if.sv
// Memory-side bus of the cache fill controller.
//   memory_read_req   : read request valid (controller -> memory)
//   memory_address    : byte address of the requested word (controller -> memory)
//   memory_ready      : memory accepts the request this cycle (memory -> controller)
//   memory_data_valid : one returned word present, in request order (memory -> controller)
interface cache_fill_ctrl_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              memory_read_req;
    logic [ADDR_W-1:0] memory_address;
    logic              memory_ready;
    logic              memory_data_valid;

    modport master (
        output memory_read_req,
        output memory_address,
        input  memory_ready,
        input  memory_data_valid
    );

    modport slave (
        input  memory_read_req,
        input  memory_address,
        output memory_ready,
        output memory_data_valid
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache miss-fill controller. On a miss it stalls the pipeline, streams one
// block from a pipelined memory into the data array word by word (requests and
// returns overlap), then writes the tag and pulses fill_done.
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   miss_detected     : cache miss this cycle, sampled only when idle
//   miss_address      : byte address of the missing access
//   mem               : memory request/return bus (master side)
//   fsm_busy          : pipeline stall
//   write_data_array  : write the returned word into the data array
//   fill_word_index   : word slot being written
//   write_tag_array   : write tag and set valid bit
//   fill_done         : one-cycle completion pulse
module cache_fill_ctrl #(
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned WORD_BYTES      = 2,
    parameter int unsigned WORDS_PER_BLOCK = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               miss_detected,
    input  logic [ADDR_W-1:0]                  miss_address,
    cache_fill_ctrl_if.master                  mem,
    output logic                               fsm_busy,
    output logic                               write_data_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_index,
    output logic                               write_tag_array,
    output logic                               fill_done
);
    localparam int unsigned IDX_W  = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned OFF_W  = $clog2(WORDS_PER_BLOCK * WORD_BYTES);
    localparam int unsigned BYTE_W = $clog2(WORD_BYTES);

    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [IDX_W-1:0]  LAST_WORD = IDX_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  req_cnt_q, req_cnt_d;
    logic [IDX_W-1:0]  ret_cnt_q, ret_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            req_cnt_q <= '0;
            ret_cnt_q <= '0;
            base_q    <= '0;
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
            ret_cnt_q <= ret_cnt_d;
            base_q    <= base_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        req_cnt_d           = req_cnt_q;
        ret_cnt_d           = ret_cnt_q;
        base_d              = base_q;
        fsm_busy            = 1'b0;
        mem.memory_read_req = 1'b0;
        mem.memory_address  = '0;
        write_data_array    = 1'b0;
        fill_word_index     = ret_cnt_q;
        write_tag_array     = 1'b0;
        fill_done           = 1'b0;

        case (state_q)
            StIdle: begin
                // Combinational stall so the miss cycle itself is held; masked
                // while reset is asserted so outputs stay low.
                fsm_busy = miss_detected & rst_n;
                if (miss_detected) begin
                    base_d    = miss_address & ~OFF_MASK;
                    req_cnt_d = '0;
                    ret_cnt_d = '0;
                    state_d   = StReq;
                end
            end
            StReq: begin
                fsm_busy            = 1'b1;
                mem.memory_read_req = 1'b1;
                // base is block-aligned, so the offset never carries past the block
                mem.memory_address  = base_q + (ADDR_W'(req_cnt_q) << BYTE_W);
                if (mem.memory_ready) begin
                    req_cnt_d = req_cnt_q + IDX_W'(1);
                    if (req_cnt_q == LAST_WORD) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                fsm_busy = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Returns are counted in both active states; with zero-latency memory
        // the final return can coincide with the final request acceptance.
        if ((state_q == StReq || state_q == StWait) && mem.memory_data_valid) begin
            write_data_array = 1'b1;
            ret_cnt_d        = ret_cnt_q + IDX_W'(1);
            if (ret_cnt_q == LAST_WORD) begin
                write_tag_array = 1'b1;
                fill_done       = 1'b1;
                state_d         = StIdle;
            end
        end
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: a default instance (16-bit address,
// 2-byte words, 8-word blocks) and a 32-bit instance (4-byte words, 4-word
// blocks), each fed by a fixed 4-cycle-latency memory model.
module tb_cache_fill_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss, miss32;
    logic [15:0] maddr;
    logic [31:0] maddr32;
    logic        ready;
    logic        stray;
    logic [3:0]  pipe, pipe32;
    logic        acc, acc32;

    logic        busy, wda, tag, done;
    logic [2:0]  idx;
    logic        busy32, wda32, tag32, done32;
    logic [1:0]  idx32;

    logic [23:0] obs;
    logic [38:0] obs32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_fill_ctrl_if #(.ADDR_W(16)) bus ();
    cache_fill_ctrl_if #(.ADDR_W(32)) bus32 ();

    assign bus.memory_ready        = ready;
    assign bus.memory_data_valid   = pipe[3] | stray;
    assign bus32.memory_ready      = ready;
    assign bus32.memory_data_valid = pipe32[3];

    cache_fill_ctrl #(
        .ADDR_W          (16),
        .WORD_BYTES      (2),
        .WORDS_PER_BLOCK (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_detected    (miss),
        .miss_address     (maddr),
        .mem              (bus),
        .fsm_busy         (busy),
        .write_data_array (wda),
        .fill_word_index  (idx),
        .write_tag_array  (tag),
        .fill_done        (done)
    );

    cache_fill_ctrl #(
        .ADDR_W          (32),
        .WORD_BYTES      (4),
        .WORDS_PER_BLOCK (4)
    ) dut32 (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_detected    (miss32),
        .miss_address     (maddr32),
        .mem              (bus32),
        .fsm_busy         (busy32),
        .write_data_array (wda32),
        .fill_word_index  (idx32),
        .write_tag_array  (tag32),
        .fill_done        (done32)
    );

    assign obs   = {busy, bus.memory_read_req, bus.memory_address, wda, idx, tag, done};
    assign obs32 = {busy32, bus32.memory_read_req, bus32.memory_address, wda32, idx32, tag32,
                    done32};

    // Expected outputs of the default instance for cycle c of a fill whose
    // miss cycle is s, with memory always ready and 4-cycle read latency.
    function automatic logic [23:0] exp_fill(input int c, input int s, input logic [15:0] b);
        int          k;
        logic        e_busy, e_req, e_wda, e_tag;
        logic [15:0] e_addr;
        logic [2:0]  e_idx;
        k      = c - s;
        e_busy = (k >= 0 && k <= 12);
        e_req  = (k >= 1 && k <= 8);
        e_addr = e_req ? b + 16'(2 * (k - 1)) : 16'h0;
        e_wda  = (k >= 5 && k <= 12);
        e_idx  = e_wda ? 3'(k - 5) : 3'd0;
        e_tag  = (k == 12);
        return {e_busy, e_req, e_addr, e_wda, e_idx, e_tag, e_tag};
    endfunction

    // Memory model: capture acceptance before the edge, then advance one cycle.
    task automatic tick();
        acc   = bus.memory_read_req & bus.memory_ready;
        acc32 = bus32.memory_read_req & bus32.memory_ready;
        @(posedge clk);
        #1;
        pipe   = {pipe[2:0], acc};
        pipe32 = {pipe32[2:0], acc32};
    endtask

    task automatic idle_cycles(input int n);
        miss   = 1'b0;
        miss32 = 1'b0;
        stray  = 1'b0;
        ready  = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        miss    = 1'b0;
        miss32  = 1'b0;
        maddr   = 16'h0;
        maddr32 = 32'h0;
        ready   = 1'b1;
        stray   = 1'b0;
        pipe    = 4'h0;
        pipe32  = 4'h0;
        #1;
        checks++;
        if (obs !== 24'h0) begin
            errors++;
            $display("FAIL reset_during got %h want %h", obs, 24'h0);
        end
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 24'h0) begin
            errors++;
            $display("FAIL reset_first_cycle got %h want %h", obs, 24'h0);
        end
        checks++;
        if (obs32 !== 39'h0) begin
            errors++;
            $display("FAIL reset32_first_cycle got %h want %h", obs32, 39'h0);
        end
        tick();
    endtask

    task automatic test_basic_fill();
        logic [23:0] e;
        for (int c = 0; c <= 13; c++) begin
            miss  = (c == 0);
            maddr = 16'h1234;
            e     = exp_fill(c, 0, 16'h1230);
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL basic_fill cyc %0d got %h want %h", c, obs, e);
            end
            tick();
        end
        idle_cycles(5);
    endtask

    task automatic test_backpressure();
        int          a_t [16] = '{0, 'h1230, 'h1232, 'h1234, 'h1234, 'h1234, 'h1236, 'h1238,
                                  'h123A, 'h123C, 'h123E, 0, 0, 0, 0, 0};
        int          w_t [16] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 0};
        int          i_t [16] = '{0, 0, 0, 0, 0, 0, 1, 2, 2, 2, 3, 4, 5, 6, 7, 0};
        logic [23:0] e;
        for (int c = 0; c < 16; c++) begin
            miss  = (c == 0);
            maddr = 16'h1234;
            ready = !(c == 3 || c == 4);
            e     = {(c <= 14), (c >= 1 && c <= 10), 16'(a_t[c]), 1'(w_t[c]), 3'(i_t[c]),
                     (c == 14), (c == 14)};
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL backpressure cyc %0d got %h want %h", c, obs, e);
            end
            tick();
        end
        idle_cycles(5);
    endtask

    task automatic test_ignored_inputs();
        logic [23:0] e;
        stray = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== 24'h0) begin
                errors++;
                $display("FAIL stray_valid cyc %0d got %h want %h", c, obs, 24'h0);
            end
            tick();
        end
        stray = 1'b0;
        for (int c = 0; c <= 13; c++) begin
            miss  = (c == 0 || c == 3);
            maddr = (c == 0) ? 16'h1234 : 16'h8000;
            e     = exp_fill(c, 0, 16'h1230);
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL miss_during_fill cyc %0d got %h want %h", c, obs, e);
            end
            tick();
        end
        idle_cycles(5);
    endtask

    task automatic test_reset_mid_fill();
        logic [23:0] e;
        for (int c = 0; c < 6; c++) begin
            miss  = (c == 0);
            maddr = 16'h1234;
            @(negedge clk);
            tick();
        end
        miss = 1'b0;
        // Cycle 6: a return is on the bus when reset hits.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 24'h0) begin
            errors++;
            $display("FAIL reset_mid_fill_async got %h want %h", obs, 24'h0);
        end
        @(negedge clk);
        tick();
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 24'h0) begin
            errors++;
            $display("FAIL reset_release got %h want %h", obs, 24'h0);
        end
        tick();
        for (int c = 8; c <= 9; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== 24'h0) begin
                errors++;
                $display("FAIL late_valid cyc %0d got %h want %h", c, obs, 24'h0);
            end
            tick();
        end
        for (int c = 0; c <= 13; c++) begin
            miss  = (c == 0);
            maddr = 16'h00F0;
            e     = exp_fill(c, 0, 16'h00F0);
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL refill_after_reset cyc %0d got %h want %h", c, obs, e);
            end
            tick();
        end
        idle_cycles(5);
    endtask

    task automatic test_back_to_back();
        logic [23:0] e;
        for (int c = 0; c <= 26; c++) begin
            miss  = (c <= 25);
            maddr = (c == 0) ? 16'h1234 : 16'h2468;
            e     = exp_fill(c, 0, 16'h1230) | exp_fill(c, 13, 16'h2460);
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL back_to_back cyc %0d got %h want %h", c, obs, e);
            end
            tick();
        end
        idle_cycles(5);
    endtask

    task automatic test_params_32();
        logic [38:0] e;
        logic        e_req, e_wda;
        logic [31:0] e_addr;
        logic [1:0]  e_idx;
        for (int c = 0; c <= 9; c++) begin
            miss32  = (c == 0);
            maddr32 = 32'hDEADBEEF;
            e_req   = (c >= 1 && c <= 4);
            e_addr  = e_req ? 32'hDEADBEE0 + 32'(4 * (c - 1)) : 32'h0;
            e_wda   = (c >= 5 && c <= 8);
            e_idx   = e_wda ? 2'(c - 5) : 2'd0;
            e       = {(c <= 8), e_req, e_addr, e_wda, e_idx, (c == 8), (c == 8)};
            @(negedge clk);
            checks++;
            if (obs32 !== e) begin
                errors++;
                $display("FAIL params_32 cyc %0d got %h want %h", c, obs32, e);
            end
            tick();
        end
        idle_cycles(5);
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_backpressure();
        test_ignored_inputs();
        test_reset_mid_fill();
        test_back_to_back();
        test_params_32();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
